// File: rtl/axis_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_if
//  Purpose  : AXI Stream handshake/data bundle with manager and subordinate views.
//  Revision : 1.0  initial release
// ============================================================================
interface axis_if #(
    parameter int TDATA_WIDTH = 8
) ();
    logic                   tvalid;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tready;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_skid_slice.sv
`default_nettype none
// ============================================================================
//  Module   : axis_skid_slice
//  Purpose  : Two-entry AXIS register slice; registers tvalid/tdata and tready.
//  Revision : 1.0  initial release
// ============================================================================
module axis_skid_slice (
    input  wire        clk,
    input  wire        rst_n,
    axis_if.m          axis_mif,
    axis_if.s          axis_sif,
    input  wire        invalidate,
    output logic [1:0] count
);
    localparam int TDATA_WIDTH = axis_mif.TDATA_WIDTH;

    if ((TDATA_WIDTH < 1) || (TDATA_WIDTH != axis_sif.TDATA_WIDTH)) begin : g_width_check
        $fatal(1, "axis_skid_slice: TDATA_WIDTH must be > 0 and match on both sides");
    end

    // State bits are {main_valid, skid_valid}; 2'b01 can never be reached.
    localparam logic [1:0] c_EMPTY = 2'b00;
    localparam logic [1:0] c_ONE   = 2'b10;
    localparam logic [1:0] c_FULL  = 2'b11;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic                   r_ready;
    logic [1:0]             r_count;
    logic                   w_ready_next;
    logic [1:0]             w_count_next;
    logic [TDATA_WIDTH-1:0] r_main_data;
    logic [TDATA_WIDTH-1:0] r_skid_data;
    logic                   w_in;
    logic                   w_out;
    logic                   w_ld_main_sif;
    logic                   w_ld_main_skid;
    logic                   w_ld_skid;

    assign w_in  = axis_sif.tvalid && r_ready;
    assign w_out = r_state[1] && axis_mif.tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_EMPTY;
            r_ready <= 1'b0;
            r_count <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_ready <= w_ready_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_ld_main_sif  = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            c_EMPTY: begin
                if (w_in) begin
                    w_state_next  = c_ONE;
                    w_ld_main_sif = 1'b1;
                end
            end
            c_ONE: begin
                if (w_in && w_out) begin
                    w_ld_main_sif = 1'b1;
                end else if (w_in) begin
                    w_state_next = c_FULL;
                    w_ld_skid    = 1'b1;
                end else if (w_out) begin
                    w_state_next = c_EMPTY;
                end
            end
            c_FULL: begin
                if (w_out) begin
                    w_state_next   = c_ONE;
                    w_ld_main_skid = 1'b1;
                end
            end
            default: w_state_next = c_EMPTY;
        endcase
        // Flush wins over any handshake; accepted input is simply discarded.
        if (invalidate) begin
            w_state_next   = c_EMPTY;
            w_ld_main_sif  = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid      = 1'b0;
        end
    end

    always_comb begin
        w_ready_next = (w_state_next != c_FULL);
        case (w_state_next)
            c_ONE:   w_count_next = 2'd1;
            c_FULL:  w_count_next = 2'd2;
            default: w_count_next = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_ld_main_sif) begin
                r_main_data <= axis_sif.tdata;
            end else if (w_ld_main_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_ld_skid) begin
                r_skid_data <= axis_sif.tdata;
            end
        end
    end

    assign axis_mif.tvalid = r_state[1];
    assign axis_mif.tdata  = r_main_data;
    assign axis_sif.tready = r_ready;
    assign count           = r_count;

    a_legal_state: assert property (@(posedge clk) disable iff (!rst_n)
        r_state != 2'b01);

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state[1] && !axis_mif.tready && !invalidate) |=>
        (axis_mif.tvalid && $stable(axis_mif.tdata)));
endmodule
`default_nettype wire

// File: tb/tb_axis_skid_slice.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_skid_slice
//  Purpose  : Scoreboard bench for axis_skid_slice.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_skid_slice;
    localparam int c_W = 16;

    logic       clk;
    logic       rst_n;
    logic       invalidate;
    logic [1:0] count;

    axis_if #(.TDATA_WIDTH(c_W)) mif_bus ();
    axis_if #(.TDATA_WIDTH(c_W)) sif_bus ();

    axis_skid_slice dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .axis_mif   (mif_bus),
        .axis_sif   (sif_bus),
        .invalidate (invalidate),
        .count      (count)
    );

    int checks = 0;
    int errors = 0;
    logic [c_W-1:0] q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: inputs and outputs are stable at negedge, handshakes resolve on the next posedge.
    logic           prev_stall = 1'b0;
    logic [c_W-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (count !== 2'(q.size())) begin
                errors++;
                $display("FAIL count_model got %0d want %0d", count, q.size());
            end
            if (prev_stall) begin
                checks++;
                if (mif_bus.tvalid !== 1'b1 || mif_bus.tdata !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable got v=%b d=%h want v=1 d=%h",
                             mif_bus.tvalid, mif_bus.tdata, prev_data);
                end
            end
            if (mif_bus.tvalid && mif_bus.tready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got %h want no beat", mif_bus.tdata);
                end else begin
                    logic [c_W-1:0] exp;
                    exp = q.pop_front();
                    if (mif_bus.tdata !== exp) begin
                        errors++;
                        $display("FAIL sb_order got %h want %h", mif_bus.tdata, exp);
                    end
                end
            end
            if (invalidate) q.delete();
            else if (sif_bus.tvalid && sif_bus.tready) q.push_back(sif_bus.tdata);
            prev_stall = mif_bus.tvalid && !mif_bus.tready && !invalidate;
            prev_data  = mif_bus.tdata;
        end
    end

    task automatic drive(input logic v, input logic [c_W-1:0] d, input logic rdy, input logic inv);
        sif_bus.tvalid = v;
        sif_bus.tdata  = d;
        mif_bus.tready = rdy;
        invalidate     = inv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        checks++;
        if (mif_bus.tvalid !== 1'b0 || sif_bus.tready !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL reset_values got v=%b r=%b c=%0d want 0 0 0",
                     mif_bus.tvalid, sif_bus.tready, count);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (sif_bus.tready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b want 0", sif_bus.tready);
        end
        tick();
        checks++;
        if (sif_bus.tready !== 1'b1 || mif_bus.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_edge got r=%b v=%b want r=1 v=0", sif_bus.tready, mif_bus.tvalid);
        end
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 17; i++) begin
            if (i > 1) begin
                checks++;
                if (mif_bus.tvalid !== 1'b1 || mif_bus.tdata !== c_W'(i - 1) ||
                    count !== 2'd1 || sif_bus.tready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_%0d got v=%b d=%h c=%0d r=%b want v=1 d=%h c=1 r=1",
                             i - 1, mif_bus.tvalid, mif_bus.tdata, count, sif_bus.tready, c_W'(i - 1));
                end
            end
            if (i <= 16) drive(1'b1, c_W'(i), 1'b1, 1'b0);
            else         drive(1'b0, '0, 1'b1, 1'b0);
            tick();
        end
        checks++;
        if (mif_bus.tvalid !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain got v=%b c=%0d want v=0 c=0", mif_bus.tvalid, count);
        end
    endtask

    // Leaves the slice FULL with {a, b}, one cycle after b was captured.
    task automatic fill_full(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        drive(1'b1, a, 1'b0, 1'b0);
        tick();
        drive(1'b1, b, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_skid();
        fill_full(16'h00AA, 16'h00BB);
        checks++;
        if (count !== 2'd2 || sif_bus.tready !== 1'b0 || mif_bus.tdata !== 16'h00AA) begin
            errors++;
            $display("FAIL skid_full got c=%0d r=%b d=%h want c=2 r=0 d=00aa",
                     count, sif_bus.tready, mif_bus.tdata);
        end
        mif_bus.tready = 1'b1;
        #1;
        checks++;
        if (sif_bus.tready !== 1'b0) begin
            errors++;
            $display("FAIL comb_path_rise got %b want 0", sif_bus.tready);
        end
        mif_bus.tready = 1'b0;
        #1;
        checks++;
        if (sif_bus.tready !== 1'b0) begin
            errors++;
            $display("FAIL comb_path_fall got %b want 0", sif_bus.tready);
        end
        tick();
        checks++;
        if (mif_bus.tdata !== 16'h00AA || count !== 2'd2) begin
            errors++;
            $display("FAIL skid_hold got d=%h c=%0d want d=00aa c=2", mif_bus.tdata, count);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        checks++;
        if (mif_bus.tdata !== 16'h00BB || sif_bus.tready !== 1'b1 || count !== 2'd1) begin
            errors++;
            $display("FAIL skid_second got d=%h r=%b c=%0d want d=00bb r=1 c=1",
                     mif_bus.tdata, sif_bus.tready, count);
        end
        tick();
        checks++;
        if (mif_bus.tvalid !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL skid_empty got v=%b c=%0d want v=0 c=0", mif_bus.tvalid, count);
        end
    endtask

    task automatic test_flush();
        fill_full(16'h0011, 16'h0022);
        drive(1'b1, 16'h0033, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (mif_bus.tvalid !== 1'b0 || count !== 2'd0 || sif_bus.tready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full got v=%b c=%0d r=%b want v=0 c=0 r=1",
                     mif_bus.tvalid, count, sif_bus.tready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mif_bus.tvalid !== 1'b0) begin
                errors++;
                $display("FAIL flush_leak got v=%b d=%h want v=0", mif_bus.tvalid, mif_bus.tdata);
            end
        end
        // Flush in ONE with simultaneous in/out handshakes: 0x44 delivered, 0x55 discarded.
        drive(1'b1, 16'h0044, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0055, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (mif_bus.tvalid !== 1'b0 || count !== 2'd0 || sif_bus.tready !== 1'b1) begin
            errors++;
            $display("FAIL flush_one got v=%b c=%0d r=%b want v=0 c=0 r=1",
                     mif_bus.tvalid, count, sif_bus.tready);
        end
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 16'h005A, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h005B, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (mif_bus.tvalid !== 1'b0 || count !== 2'd0 || sif_bus.tready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b c=%0d r=%b want 0 0 0",
                     mif_bus.tvalid, count, sif_bus.tready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (sif_bus.tready !== 1'b1 || mif_bus.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL async_recover got r=%b v=%b want r=1 v=0", sif_bus.tready, mif_bus.tvalid);
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int cyc  = 0;
        int pv   = 60;
        int pr   = 60;
        logic v;
        while (sent < 10000 && cyc < 60000) begin
            if (cyc % 400 == 0) begin
                pv = $urandom_range(90, 30);
                pr = $urandom_range(90, 30);
            end
            v = ($urandom_range(99, 0) < pv);
            if (v && sif_bus.tready) sent++;
            drive(v, c_W'($urandom), ($urandom_range(99, 0) < pr), 1'b0);
            tick();
            cyc++;
        end
        checks++;
        if (sent < 10000) begin
            errors++;
            $display("FAIL random_budget got %0d beats want 10000", sent);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10 && mif_bus.tvalid; i++) tick();
        tick();
        checks++;
        if (q.size() != 0 || mif_bus.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain got q=%0d v=%b want q=0 v=0", q.size(), mif_bus.tvalid);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
